// File: rtl/fetch_sequencer.sv
// Fetch stage: program counter, zero flag, branch resolution and a small
// return-address stack feeding the control unit.
module fetch_sequencer #(
  parameter int PC_W        = 10,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stall_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         opcode_o,
  input  logic               wez_i,
  input  logic               alu_zero_i,
  output logic               zflag_o,
  output logic               branch_taken_o,
  output logic               stack_err_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH_C = SP_W'(STACK_DEPTH);

  localparam logic [5:0] OP_J    = 6'b111100;
  localparam logic [5:0] OP_JZ   = 6'b111101;
  localparam logic [5:0] OP_JNZ  = 6'b111110;
  localparam logic [5:0] OP_CALL = 6'b111000;
  localparam logic [5:0] OP_RET  = 6'b111001;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            zflag_q, zflag_d;
  logic            taken_q, taken_d;
  logic            err_q, err_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];

  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [PC_W-1:0]  seq_pc, tgt_pc;
  logic [SP_W-1:0]  sp_m1;

  assign instr_o        = imem_data_i;
  assign opcode_o       = imem_data_i[INSTR_W-1 -: 6];
  assign imem_addr_o    = pc_q;
  assign zflag_o        = zflag_q;
  assign branch_taken_o = taken_q;
  assign stack_err_o    = err_q;

  assign seq_pc = pc_q + 1'b1;
  assign tgt_pc = imem_data_i[PC_W-1:0];
  assign sp_m1  = sp_q - 1'b1;

  always_comb begin
    pc_d     = pc_q;
    zflag_d  = zflag_q;
    taken_d  = taken_q;
    err_d    = err_q;
    sp_d     = sp_q;
    push_en  = 1'b0;
    push_idx = sp_q[IDX_W-1:0];
    if (!stall_i) begin
      // Branch decisions use the flag value from before this instruction.
      if (wez_i) zflag_d = alu_zero_i;
      pc_d    = seq_pc;
      taken_d = 1'b0;
      unique case (opcode_o)
        OP_J: begin
          pc_d    = tgt_pc;
          taken_d = 1'b1;
        end
        OP_JZ: begin
          if (zflag_q) begin
            pc_d    = tgt_pc;
            taken_d = 1'b1;
          end
        end
        OP_JNZ: begin
          if (!zflag_q) begin
            pc_d    = tgt_pc;
            taken_d = 1'b1;
          end
        end
        OP_CALL: begin
          if (sp_q < DEPTH_C) begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
            pc_d    = tgt_pc;
            taken_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RET: begin
          if (sp_q != '0) begin
            sp_d    = sp_m1;
            pc_d    = stack_q[sp_m1[IDX_W-1:0]];
            taken_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q    <= '0;
      zflag_q <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      zflag_q <= zflag_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
      for (int i = 0; i < STACK_DEPTH; i++)
        if (push_en && (push_idx == IDX_W'(i))) stack_q[i] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction words are driven directly,
// expected PC/flags are hand-computed per cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, wez, alu_zero;
  logic [9:0]  imem_addr;
  logic [15:0] imem_data, instr;
  logic [5:0]  opcode;
  logic        zflag, branch_taken, stack_err;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.PC_W(10), .INSTR_W(16), .STACK_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .instr_o(instr), .opcode_o(opcode),
    .wez_i(wez), .alu_zero_i(alu_zero),
    .zflag_o(zflag), .branch_taken_o(branch_taken), .stack_err_o(stack_err)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] J = 6'b111100, JZ = 6'b111101, JNZ = 6'b111110;
  localparam logic [5:0] CALL = 6'b111000, RET = 6'b111001, NOP = 6'b000000;

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One instruction cycle: drive mid-cycle, check decode, then check state after the edge.
  task automatic cyc(input string nm, input logic rst, input logic st, input logic w,
                     input logic az, input logic [15:0] ins, input logic [9:0] e_pc,
                     input logic e_tk, input logic e_z, input logic e_err);
    @(negedge clk);
    reset = rst; stall = st; wez = w; alu_zero = az; imem_data = ins;
    #1;
    chk({nm, ".opcode"}, 32'(opcode), 32'(ins[15:10]));
    chk({nm, ".instr"}, 32'(instr), 32'(ins));
    @(posedge clk);
    #1;
    chk({nm, ".pc"}, 32'(imem_addr), 32'(e_pc));
    chk({nm, ".taken"}, 32'(branch_taken), 32'(e_tk));
    chk({nm, ".zflag"}, 32'(zflag), 32'(e_z));
    chk({nm, ".err"}, 32'(stack_err), 32'(e_err));
  endtask

  typedef struct {
    logic        st, w, az;
    logic [15:0] ins;
    logic [9:0]  pc;
    logic        tk, z, err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic w, input logic az,
                              input logic [15:0] ins, input logic [9:0] pc,
                              input logic tk, input logic z, input logic err);
    vec_t v;
    v.st = st; v.w = w; v.az = az; v.ins = ins;
    v.pc = pc; v.tk = tk; v.z = z; v.err = err;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; wez = 1'b0; alu_zero = 1'b0; imem_data = '0;

    cyc("rst0", 1, 0, 0, 0, 16'h0, 10'h0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 16'h0, 10'h0, 0, 0, 0);
    cyc("seq1", 0, 0, 0, 0, 16'h0, 10'h1, 0, 0, 0);
    cyc("seq2", 0, 0, 0, 0, 16'h0, 10'h2, 0, 0, 0);
    cyc("seq3", 0, 0, 0, 0, 16'h0, 10'h3, 0, 0, 0);

    // stall, wez, alu_zero, instr, expected pc, taken, zflag, stack_err
    add(0, 0, 0, mk(J, 10'd5),      10'd5,   1, 0, 0);
    add(0, 1, 1, mk(NOP, 10'h0),    10'd6,   0, 1, 0);
    add(0, 0, 0, mk(J, 10'd5),      10'd5,   1, 1, 0);
    add(0, 0, 0, mk(JZ, 10'h040),   10'h040, 1, 1, 0);
    add(0, 0, 0, mk(J, 10'd5),      10'd5,   1, 1, 0);
    add(0, 1, 0, mk(NOP, 10'h0),    10'd6,   0, 0, 0);
    add(0, 0, 0, mk(J, 10'd5),      10'd5,   1, 0, 0);
    add(0, 0, 0, mk(JZ, 10'h040),   10'd6,   0, 0, 0);
    add(0, 0, 0, mk(JNZ, 10'h080),  10'h080, 1, 0, 0);
    add(0, 1, 1, mk(JZ, 10'h040),   10'h081, 0, 1, 0);
    add(0, 0, 0, mk(JZ, 10'h040),   10'h040, 1, 1, 0);
    add(0, 0, 0, mk(JNZ, 10'h300),  10'h041, 0, 1, 0);
    add(0, 0, 0, {6'b111111, 10'h200}, 10'h042, 0, 1, 0);
    add(0, 0, 0, {6'b111010, 10'h200}, 10'h043, 0, 1, 0);
    add(0, 0, 0, {6'b111011, 10'h200}, 10'h044, 0, 1, 0);
    add(0, 0, 0, mk(J, 10'h010),    10'h010, 1, 1, 0);
    add(1, 1, 0, mk(J, 10'h3FF),    10'h010, 1, 1, 0);
    add(1, 1, 0, mk(NOP, 10'h0),    10'h010, 1, 1, 0);
    add(1, 1, 0, mk(RET, 10'h0),    10'h010, 1, 1, 0);
    add(0, 0, 0, mk(CALL, 10'h100), 10'h100, 1, 1, 0);
    add(0, 0, 0, mk(CALL, 10'h200), 10'h200, 1, 1, 0);
    add(0, 0, 0, mk(RET, 10'h0),    10'h101, 1, 1, 0);
    add(0, 0, 0, mk(RET, 10'h0),    10'h011, 1, 1, 0);
    add(0, 0, 0, mk(J, 10'h3FF),    10'h3FF, 1, 1, 0);
    add(0, 0, 0, mk(NOP, 10'h0),    10'h000, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++)
      cyc($sformatf("vec%0d", i), 0, vecs[i].st, vecs[i].w, vecs[i].az, vecs[i].ins,
          vecs[i].pc, vecs[i].tk, vecs[i].z, vecs[i].err);

    // Overflow at depth 4, unwind, then underflow
    cyc("ovf_c1", 0, 0, 0, 0, mk(CALL, 10'h100), 10'h100, 1, 1, 0);
    cyc("ovf_c2", 0, 0, 0, 0, mk(CALL, 10'h200), 10'h200, 1, 1, 0);
    cyc("ovf_c3", 0, 0, 0, 0, mk(CALL, 10'h300), 10'h300, 1, 1, 0);
    cyc("ovf_c4", 0, 0, 0, 0, mk(CALL, 10'h050), 10'h050, 1, 1, 0);
    cyc("ovf_c5", 0, 0, 0, 0, mk(CALL, 10'h060), 10'h051, 0, 1, 1);
    cyc("ovf_r1", 0, 0, 0, 0, mk(RET, 10'h0),    10'h301, 1, 1, 1);
    cyc("ovf_r2", 0, 0, 0, 0, mk(RET, 10'h0),    10'h201, 1, 1, 1);
    cyc("ovf_r3", 0, 0, 0, 0, mk(RET, 10'h0),    10'h101, 1, 1, 1);
    cyc("ovf_r4", 0, 0, 0, 0, mk(RET, 10'h0),    10'h001, 1, 1, 1);
    cyc("unf_r5", 0, 0, 0, 0, mk(RET, 10'h0),    10'h002, 0, 1, 1);
    cyc("err_rst", 1, 0, 0, 0, mk(NOP, 10'h0),   10'h000, 0, 0, 0);

    // Reset mid-operation discards pushed return addresses
    cyc("disc_call", 0, 0, 0, 0, mk(CALL, 10'h100), 10'h100, 1, 0, 0);
    cyc("disc_rst",  1, 0, 0, 0, mk(NOP, 10'h0),    10'h000, 0, 0, 0);
    cyc("disc_ret",  0, 0, 0, 0, mk(RET, 10'h0),    10'h001, 0, 0, 1);

    // Reset overrides stall
    cyc("sr_j",    0, 0, 1, 1, mk(J, 10'h123), 10'h123, 1, 1, 1);
    cyc("sr_hold", 0, 1, 0, 0, mk(NOP, 10'h0), 10'h123, 1, 1, 1);
    cyc("sr_rst",  1, 1, 0, 0, mk(NOP, 10'h0), 10'h000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
